// File: rtl/isr_pkg.sv
// ---------------------------------------------------------------------------
// isr_pkg
//
// Shared definitions for the interrupt entry/exit sequencer:
//   - default PC/vector width and saved-flag width
//   - sequencer state encoding (IDLE=0, VECTOR=1, ISR=2, RETURN=3)
//   - small helpers used when decoding the registered state
// ---------------------------------------------------------------------------
package isr_pkg;

    // Default widths: 8-bit program counter / ISR vector, {overflow, zero}
    localparam int AW_DEFAULT = 8;
    localparam int FW_DEFAULT = 2;

    // Sequencer state encoding. Kept as plain constants so legacy code that
    // compares against raw 2-bit values keeps working.
    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_VECTOR = 2'd1;
    localparam state_t ST_ISR    = 2'd2;
    localparam state_t ST_RETURN = 2'd3;

    // The two single-cycle states both redirect the PC and stall fetch.
    function automatic logic is_redirect_state(input state_t s);
        return (s == ST_VECTOR) || (s == ST_RETURN);
    endfunction

    // Next value of the global interrupt enable for one instruction
    // boundary. cli dominates when both are set in the same instruction.
    function automatic logic next_gie(input logic gie_cur,
                                      input logic boundary,
                                      input logic set_en,
                                      input logic clr_en);
        logic result;
        result = gie_cur;
        if (boundary) begin
            if (clr_en) begin
                result = 1'b0;
            end else if (set_en) begin
                result = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/isr_sequencer_context.sv
// ---------------------------------------------------------------------------
// isr_context
//
// Interrupt context storage: the return address, the captured ISR vector and
// the ALU flags saved at interrupt entry. All three registers load together
// when capture is high and are wiped by the asynchronous clear, so a reset
// during an ISR leaves no stale context behind.
//
// Ports:
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-high clear
//   capture    in   load all context registers this edge
//   pc_in      in   AW  address to return to after the ISR
//   vec_in     in   AW  ISR entry address
//   flags_in   in   FW  ALU flags to preserve across the ISR
//   ret_pc     out  AW  saved return address
//   vec        out  AW  saved ISR vector
//   flags_sav  out  FW  saved ALU flags
// ---------------------------------------------------------------------------
module isr_context
    import isr_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int FW = FW_DEFAULT
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          capture,
    input  logic [AW-1:0] pc_in,
    input  logic [AW-1:0] vec_in,
    input  logic [FW-1:0] flags_in,
    output logic [AW-1:0] ret_pc,
    output logic [AW-1:0] vec,
    output logic [FW-1:0] flags_sav
);

    // Context registers. They only change on an interrupt entry edge, which
    // is what makes vec_in a one-shot sample: later changes on the vector
    // bus have no effect until the next entry.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ret_pc    <= '0;
            vec       <= '0;
            flags_sav <= '0;
        end else if (capture) begin
            ret_pc    <= pc_in;
            vec       <= vec_in;
            flags_sav <= flags_in;
        end
    end

endmodule

// File: rtl/isr_sequencer.sv
// ---------------------------------------------------------------------------
// isr_sequencer
//
// Single-level interrupt entry/exit sequencer sitting between the vectored
// priority interrupt controller and the CPU program counter. It waits for an
// instruction boundary with a pending, globally enabled interrupt, saves the
// return address and ALU flags, redirects the PC to the ISR vector, masks the
// priority encoder while the ISR runs, and on RETI restores PC and flags.
//
// Ports:
//   clk         in   system clock, rising edge
//   clr         in   asynchronous active-high reset
//   i_pending   in   interrupt pending from the interrupt controller
//   vec_in      in   AW  ISR address from the interrupt controller
//   pc_cur      in   AW  address of the next instruction to execute
//   flags_in    in   FW  current ALU flags
//   instr_done  in   one-cycle strobe, last cycle of an instruction
//   reti        in   current instruction is RETI (qualified by instr_done)
//   sei         in   set global interrupt enable (qualified by instr_done)
//   cli         in   clear global interrupt enable (qualified by instr_done)
//   irq_enable  out  enable for the interrupt controller
//   pc_load     out  CPU loads pc_next this edge
//   pc_next     out  AW  PC value to load
//   flags_load  out  CPU loads flags_out this edge
//   flags_out   out  FW  restored flags
//   hold        out  stall instruction fetch
//   irq_ack     out  one-cycle pulse while the vector is loaded
//   reti_err    out  one-cycle pulse after a RETI outside an ISR
//   in_isr      out  sequencer is in the ISR state
// ---------------------------------------------------------------------------
module isr_sequencer
    import isr_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int FW = FW_DEFAULT
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_pending,
    input  logic [AW-1:0] vec_in,
    input  logic [AW-1:0] pc_cur,
    input  logic [FW-1:0] flags_in,
    input  logic          instr_done,
    input  logic          reti,
    input  logic          sei,
    input  logic          cli,
    output logic          irq_enable,
    output logic          pc_load,
    output logic [AW-1:0] pc_next,
    output logic          flags_load,
    output logic [FW-1:0] flags_out,
    output logic          hold,
    output logic          irq_ack,
    output logic          reti_err,
    output logic          in_isr
);

    state_t        state;
    state_t        state_nxt;
    logic          gie;
    logic          gie_nxt;
    logic          entry;
    logic          reti_in_idle;
    logic          reti_err_q;
    logic [AW-1:0] ret_pc;
    logic [AW-1:0] vec;
    logic [FW-1:0] flags_sav;

    // Entry decision uses the gie value from before this edge, so a cli in
    // the same instruction that ends at this boundary does not cancel the
    // interrupt; it only leaves gie cleared once the handler returns.
    assign entry        = (state == ST_IDLE) & i_pending & gie & instr_done;
    assign reti_in_idle = (state == ST_IDLE) & reti & instr_done;

    // Context storage, loaded on the entry edge only.
    isr_context #(
        .AW (AW),
        .FW (FW)
    ) u_context (
        .clk       (clk),
        .clr       (clr),
        .capture   (entry),
        .pc_in     (pc_cur),
        .vec_in    (vec_in),
        .flags_in  (flags_in),
        .ret_pc    (ret_pc),
        .vec       (vec),
        .flags_sav (flags_sav)
    );

    // Next-state logic. VECTOR and RETURN each last exactly one cycle; the
    // ISR state ignores i_pending entirely because nesting is not supported.
    // RETURN always goes back to IDLE, so a still-pending interrupt can only
    // be taken at a later boundary seen from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (entry) begin
                    state_nxt = ST_VECTOR;
                end
            end
            ST_VECTOR: begin
                state_nxt = ST_ISR;
            end
            ST_ISR: begin
                if (reti && instr_done) begin
                    state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Global interrupt enable follows sei/cli at every instruction boundary,
    // regardless of state.
    always_comb begin
        gie_nxt = next_gie(gie, instr_done, sei, cli);
    end

    // State, gie and the RETI-error pulse. A reset in any state abandons
    // the current interrupt context.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_IDLE;
            gie        <= 1'b0;
            reti_err_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            gie        <= gie_nxt;
            reti_err_q <= reti_in_idle;
        end
    end

    // Output decode. Everything is a function of registered state and
    // registered context, so each strobe lasts exactly one cycle and none of
    // them depends combinationally on the CPU-side inputs.
    always_comb begin
        irq_enable = gie & (state == ST_IDLE);
        pc_load    = is_redirect_state(state);
        hold       = is_redirect_state(state);
        irq_ack    = (state == ST_VECTOR);
        flags_load = (state == ST_RETURN);
        in_isr     = (state == ST_ISR);
        reti_err   = reti_err_q;
        pc_next    = '0;
        flags_out  = '0;
        if (state == ST_VECTOR) begin
            pc_next = vec;
        end else if (state == ST_RETURN) begin
            pc_next   = ret_pc;
            flags_out = flags_sav;
        end
    end

`ifndef SYNTHESIS
    // Redirect strobes never stretch past one cycle and always stall fetch.
    a_ack_one_cycle : assert property (@(posedge clk) disable iff (clr)
        irq_ack |=> !irq_ack);
    a_load_holds : assert property (@(posedge clk) disable iff (clr)
        pc_load |-> hold);
    a_flags_with_pc : assert property (@(posedge clk) disable iff (clr)
        flags_load |-> pc_load);
`endif

endmodule

// File: doc/isr_sequencer.md
# isr_sequencer

Interrupt entry/exit sequencer that consumes the pending flag and 8-bit ISR vector from the maskable vectored priority interrupt system (MHVPIS) and drives the CPU program counter. It waits for an instruction boundary, saves the return address and ALU flags, loads the vector, and gates the priority encoder's enable while an ISR runs. On return-from-interrupt it restores PC and flags. Single-level: no nesting.

## Interface
Parameters:
- AW, 8, PC/vector width
- FW, 2, saved ALU flag width ({overflow, zero})

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- i_pending  in  1  interrupt pending from MHVPIS
- vec_in  in  AW  ISR address from MHVPIS PC_out
- pc_cur  in  AW  address of next instruction to execute
- flags_in  in  FW  current ALU flags
- instr_done  in  1  one-cycle strobe, last cycle of an instruction
- reti  in  1  current instruction is RETI (qualified by instr_done)
- sei  in  1  set global interrupt enable (qualified by instr_done)
- cli  in  1  clear global interrupt enable (qualified by instr_done)
- irq_enable  out  1  drives MHVPIS enable
- pc_load  out  1  CPU loads pc_next this edge
- pc_next  out  AW  PC value to load
- flags_load  out  1  CPU loads flags_out this edge
- flags_out  out  FW  restored flags
- hold  out  1  stall fetch
- irq_ack  out  1  one-cycle pulse on vector load
- reti_err  out  1  one-cycle pulse, RETI outside an ISR
- in_isr  out  1  state is ISR

## Operation
- States: IDLE, VECTOR, ISR, RETURN. Encoding in the package.
- gie register. Reset 0. sei/cli take effect on an instr_done edge. Both asserted: cli wins.
- IDLE: on an edge with i_pending & gie & instr_done, capture ret_pc<=pc_cur, vec<=vec_in, flags_sav<=flags_in, and go to VECTOR. Otherwise stay in IDLE. sei/cli on the same boundary update gie, but entry uses the pre-edge gie.
- VECTOR (1 cycle): pc_load=1, pc_next=vec, irq_ack=1, hold=1. Next state is ISR.
- ISR: i_pending is ignored. reti & instr_done goes to RETURN. sei/cli still update gie.
- RETURN (1 cycle): pc_load=1, pc_next=ret_pc, flags_load=1, flags_out=flags_sav, hold=1. Next state is IDLE.
- reti & instr_done in IDLE: reti_err pulses the next cycle. State is unchanged.
- irq_enable = gie & (state==IDLE). Combinational from registers.
- i_pending dropping before a boundary: no entry and no side effect.
- Interrupt pending on the RETURN→IDLE transition: entry occurs at the next instr_done after IDLE, never in the same cycle as RETURN.

## Timing
- Reset (async, immediate): state=IDLE, gie=0, ret_pc=0, vec=0, flags_sav=0. All outputs 0, pc_next=0, flags_out=0.
- Reset mid-ISR or mid-VECTOR: abandons the context and returns to IDLE.
- Entry latency: the instr_done edge is edge 0. pc_load is high in cycle 1 and the CPU loads vec at edge 1. The ISR starts fetching in cycle 2.
- Exit latency: the RETI instr_done edge is edge 0. RETURN is cycle 1, and ret_pc and flags are loaded at edge 1.
- pc_load, flags_load, irq_ack and reti_err are exactly one cycle wide and registered-state-derived.
- vec_in is sampled only at the entry edge. Later changes do not affect pc_next.

## Structure
- Package isr_pkg holds:
  - state enum (IDLE=0, VECTOR=1, ISR=2, RETURN=3)
  - default AW and FW constants
- One sub-module, isr_context: holds ret_pc, vec and flags_sav with a capture enable and async clear.
- The FSM and gie logic stay in isr_sequencer.

## Test plan
- Reset: assert clr mid-cycle, then release. All outputs are 0 and irq_enable=0. sei@instr_done then gives irq_enable=1.
- Basic entry/exit:
  - Setup: gie=1, i_pending=1, vec_in=0xF0, pc_cur=0x42, flags_in=2'b10, instr_done.
  - Entry: next cycle pc_load=1, pc_next=0xF0, irq_ack=1, hold=1. Then in_isr=1 and irq_enable=0.
  - Exit: RETI@instr_done gives pc_next=0x42, flags_out=2'b10, flags_load=1, then IDLE.
- No entry without a boundary or with gie=0: i_pending=1 for 10 cycles with instr_done=0 gives no pc_load. With gie=0 and instr_done=1, still no pc_load.
- Simultaneous events:
  - sei & cli on one boundary gives gie=0.
  - cli on the entry boundary with gie=1 still enters the ISR, and gie=0 afterward.
- RETI in IDLE gives a reti_err pulse, pc_load=0, state IDLE.
- Reset mid-ISR: clr in the ISR state gives in_isr=0 and ret_pc=0. A subsequent RETI gives reti_err=1.
